blob_merge_ctrl: RTL and testbench

- Frame-level sequencer and owner of the label-equivalence table for the connected-component labeler.
- During a frame, accepts merge requests from the labeling datapath.
- At frame end, flattens the table so every entry points directly at its root label.
- Then streams the resolved label→root map to downstream logic (relabel LUT loader, blob statistics) over a valid/ready handshake, and returns to idle.

---
 rtl/blob_merge_ctrl.sv | 178 +++++++++++++++++
 tb/tb_blob_merge_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/blob_merge_ctrl.sv
// blob_merge_ctrl: frame sequencer and label-equivalence table owner for the
// connected-component labeler. It collects merges during a frame, flattens the
// table in one ascending pass at frame end, and then streams the label->root map.
// The optional macro BLOB_ROOT_COUNT_EN adds the obj_count output, which counts
// the root labels found during flattening.
module blob_merge_ctrl #(
    parameter int LABEL_BITS = 4,
    parameter int MAX_OBJ    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  frame_end,
    input  logic [LABEL_BITS-1:0] max_label,
    input  logic                  merge_valid,
    input  logic [LABEL_BITS-1:0] merge_a,
    input  logic [LABEL_BITS-1:0] merge_b,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [LABEL_BITS-1:0] rd_idx,
    output logic [LABEL_BITS-1:0] rd_root,
    output logic                  busy,
    output logic                  done,
    output logic                  err_overrun,
    output logic                  merge_ign
`ifdef BLOB_ROOT_COUNT_EN
    ,
    output logic [LABEL_BITS-1:0] obj_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLATTEN = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // One extra bit so that MAX_OBJ == 2^LABEL_BITS is still representable.
    localparam logic [LABEL_BITS:0]   MAX_OBJ_W = (LABEL_BITS + 1)'(MAX_OBJ);
    localparam logic [LABEL_BITS-1:0] LAST_LBL  = LABEL_BITS'(MAX_OBJ - 1);
    localparam logic [LABEL_BITS-1:0] ONE       = LABEL_BITS'(1);

    state_t                state_q, state_d;
    logic [LABEL_BITS-1:0] tbl [MAX_OBJ];
    logic [LABEL_BITS-1:0] idx_q;
    logic [LABEL_BITS-1:0] n_q;
    logic                  done_q, done_d;
    logic                  ovr_q, ovr_d;
    logic                  ign_q, ign_d;

    logic                  m_bad;
    logic [LABEL_BITS-1:0] lo, hi, p;
    logic                  merge_wr;
    logic [LABEL_BITS-1:0] wr_addr, wr_data;
    logic [LABEL_BITS-1:0] n_clip;
    logic [LABEL_BITS-1:0] flat_root;

`ifdef BLOB_ROOT_COUNT_EN
    logic [LABEL_BITS-1:0] cnt_q;
    assign obj_count = cnt_q;
`endif

    // Merge decode, frame-end clipping, flatten lookup and FSM next state.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;

        m_bad = (merge_a == '0) || (merge_b == '0) || (merge_a == merge_b) ||
                ({1'b0, merge_a} >= MAX_OBJ_W) || ({1'b0, merge_b} >= MAX_OBJ_W);
        lo = (merge_a < merge_b) ? merge_a : merge_b;
        hi = (merge_a < merge_b) ? merge_b : merge_a;
        // hi may be out of range on a rejected request; never look it up then.
        p  = m_bad ? lo : tbl[hi];
        merge_wr = (state_q == COLLECT) && merge_valid && !m_bad && (p != lo);
        // Link the larger of the two roots under the smaller one, so table[i] <= i.
        wr_addr  = (p > lo) ? p : lo;
        wr_data  = (p > lo) ? lo : p;

        n_clip = ({1'b0, max_label} >= MAX_OBJ_W) ? LAST_LBL : max_label;

        // The parent index is smaller than idx, so it has already been flattened.
        flat_root = tbl[tbl[idx_q]];

        ign_d = merge_valid && ((state_q != COLLECT) || m_bad);
        ovr_d = frame_start && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (frame_start) state_d = COLLECT;
            end
            COLLECT: begin
                if (frame_end) begin
                    if (n_clip == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FLATTEN;
                    end
                end
            end
            FLATTEN: begin
                if (idx_q == n_q) state_d = DRAIN;
            end
            DRAIN: begin
                if (rd_ready && (idx_q == n_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and the one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ign_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            ign_q   <= ign_d;
        end
    end

    // Equivalence table, the walk index, the latched entry count and the root counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OBJ; i++) tbl[i] <= LABEL_BITS'(i);
            idx_q <= '0;
            n_q   <= '0;
`ifdef BLOB_ROOT_COUNT_EN
            cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    for (int i = 0; i < MAX_OBJ; i++) tbl[i] <= LABEL_BITS'(i);
                    idx_q <= ONE;
`ifdef BLOB_ROOT_COUNT_EN
                    if (frame_start) cnt_q <= '0;
`endif
                end
                COLLECT: begin
                    if (merge_wr) tbl[wr_addr] <= wr_data;
                    if (frame_end) begin
                        n_q   <= n_clip;
                        idx_q <= ONE;
                    end
                end
                FLATTEN: begin
                    tbl[idx_q] <= flat_root;
`ifdef BLOB_ROOT_COUNT_EN
                    if (flat_root == idx_q) cnt_q <= cnt_q + ONE;
`endif
                    idx_q <= (idx_q == n_q) ? ONE : idx_q + ONE;
                end
                DRAIN: begin
                    if (rd_ready) idx_q <= (idx_q == n_q) ? ONE : idx_q + ONE;
                end
                default: idx_q <= ONE;
            endcase
        end
    end

    assign rd_valid    = (state_q == DRAIN);
    assign rd_idx      = rd_valid ? idx_q : '0;
    assign rd_root     = rd_valid ? tbl[idx_q] : '0;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err_overrun = ovr_q;
    assign merge_ign   = ign_q;

endmodule

// File: tb/tb_blob_merge_ctrl.sv
// Self-checking bench for blob_merge_ctrl: table-driven frames plus directed
// corner sequences (backpressure, ignored events, empty/clipped frames, reset).
module tb_blob_merge_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       frame_end = 1'b0;
    logic [3:0] max_label = '0;
    logic       merge_valid = 1'b0;
    logic [3:0] merge_a = '0;
    logic [3:0] merge_b = '0;
    logic       rd_ready = 1'b0;
    logic       rd_valid, busy, done, err_overrun, merge_ign;
    logic [3:0] rd_idx, rd_root;
`ifdef BLOB_ROOT_COUNT_EN
    logic [3:0] obj_count;
`endif

    int checks = 0;
    int errors = 0;

    blob_merge_ctrl #(.LABEL_BITS(4), .MAX_OBJ(10)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
        .max_label(max_label), .merge_valid(merge_valid), .merge_a(merge_a),
        .merge_b(merge_b), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_idx(rd_idx),
        .rd_root(rd_root), .busy(busy), .done(done), .err_overrun(err_overrun),
        .merge_ign(merge_ign)
`ifdef BLOB_ROOT_COUNT_EN
        , .obj_count(obj_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int              nm;
        logic [2:0][3:0] ma;
        logic [2:0][3:0] mb;
        logic [3:0]      ml;
        int              n;
        logic [9:0][3:0] roots;
        int              cnt;
    } vec_t;

    vec_t vt [4];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0][3:0] ident();
        logic [9:0][3:0] r;
        for (int i = 0; i < 10; i++) r[i] = 4'(i);
        return r;
    endfunction

    task automatic start_frame(input string tag);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk({tag, " busy after start"}, 16'(busy), 16'd1);
    endtask

    task automatic do_merge(input logic [3:0] a, input logic [3:0] b, input logic exp_ign,
                            input string tag);
        merge_valid = 1'b1;
        merge_a     = a;
        merge_b     = b;
        @(negedge clk);
        merge_valid = 1'b0;
        chk($sformatf("%s merge_ign(%0d,%0d)", tag, a, b), 16'(merge_ign), 16'(exp_ign));
    endtask

    task automatic end_frame(input logic [3:0] ml);
        frame_end = 1'b1;
        max_label = ml;
        @(negedge clk);
        frame_end = 1'b0;
    endtask

    // Waits for the first beat, then accepts n beats checking index and root.
    task automatic run_drain(input string tag, input int n, input logic [9:0][3:0] roots,
                             input int lat, input int stall_beat, input int stall_len,
                             input int ovr_beat);
        int w = 0;
        rd_ready = 1'b1;
        while (!rd_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " first rd_valid latency"}, 16'(w), 16'(lat));
        for (int i = 1; i <= n; i++) begin
            chk($sformatf("%s rd_valid beat%0d", tag, i), 16'(rd_valid), 16'd1);
            if (!rd_valid) break;
            if (i == stall_beat) begin
                rd_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    chk($sformatf("%s stall%0d valid", tag, s), 16'(rd_valid), 16'd1);
                    chk($sformatf("%s stall%0d idx", tag, s), 16'(rd_idx), 16'(i));
                    chk($sformatf("%s stall%0d root", tag, s), 16'(rd_root), 16'(roots[i]));
                end
                rd_ready = 1'b1;
            end
            chk($sformatf("%s rd_idx beat%0d", tag, i), 16'(rd_idx), 16'(i));
            chk($sformatf("%s rd_root beat%0d", tag, i), 16'(rd_root), 16'(roots[i]));
            chk($sformatf("%s done early beat%0d", tag, i), 16'(done), 16'd0);
            if (i == ovr_beat) frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
            if (i == ovr_beat) chk({tag, " err_overrun"}, 16'(err_overrun), 16'd1);
        end
        chk({tag, " rd_valid after last"}, 16'(rd_valid), 16'd0);
        chk({tag, " done pulse"}, 16'(done), 16'd1);
        chk({tag, " idle after drain"}, 16'(busy), 16'd0);
        @(negedge clk);
        chk({tag, " done one cycle"}, 16'(done), 16'd0);
    endtask

    task automatic run_frame(input vec_t v, input int stall_beat, input int stall_len,
                             input string tag);
        start_frame(tag);
        for (int m = 0; m < v.nm; m++) do_merge(v.ma[m], v.mb[m], 1'b0, tag);
        end_frame(v.ml);
        run_drain(tag, v.n, v.roots, v.n, stall_beat, stall_len, 0);
`ifdef BLOB_ROOT_COUNT_EN
        chk({tag, " obj_count"}, 16'(obj_count), 16'(v.cnt));
`endif
    endtask

    initial begin
        logic [9:0][3:0] r;
        int w;

        // Vector 0: no merges, three labels, every label is its own root.
        vt[0].nm = 0; vt[0].ma = '0; vt[0].mb = '0; vt[0].ml = 4'd3; vt[0].n = 3;
        vt[0].roots = ident(); vt[0].cnt = 3;
        // Vector 1: chain 3-2-1 collapses onto label 1.
        vt[1].nm = 2; vt[1].ma = '0; vt[1].mb = '0;
        vt[1].ma[0] = 4'd3; vt[1].mb[0] = 4'd2; vt[1].ma[1] = 4'd2; vt[1].mb[1] = 4'd1;
        vt[1].ml = 4'd3; vt[1].n = 3; vt[1].roots = ident();
        vt[1].roots[2] = 4'd1; vt[1].roots[3] = 4'd1; vt[1].cnt = 1;
        // Vector 2: (4,1),(4,3),(5,3); label 2 stays alone.
        vt[2].nm = 3; vt[2].ma = '0; vt[2].mb = '0;
        vt[2].ma[0] = 4'd4; vt[2].mb[0] = 4'd1; vt[2].ma[1] = 4'd4; vt[2].mb[1] = 4'd3;
        vt[2].ma[2] = 4'd5; vt[2].mb[2] = 4'd3;
        vt[2].ml = 4'd5; vt[2].n = 5; vt[2].roots = ident();
        vt[2].roots[3] = 4'd1; vt[2].roots[4] = 4'd1; vt[2].roots[5] = 4'd1; vt[2].cnt = 2;
        // Vector 3: (9,8) then (7,9) relinks root 8 under 7 through the parent.
        vt[3].nm = 2; vt[3].ma = '0; vt[3].mb = '0;
        vt[3].ma[0] = 4'd9; vt[3].mb[0] = 4'd8; vt[3].ma[1] = 4'd7; vt[3].mb[1] = 4'd9;
        vt[3].ml = 4'd9; vt[3].n = 9; vt[3].roots = ident();
        vt[3].roots[8] = 4'd7; vt[3].roots[9] = 4'd7; vt[3].cnt = 7;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset rd_valid", 16'(rd_valid), 16'd0);
        chk("reset busy", 16'(busy), 16'd0);
        chk("reset done", 16'(done), 16'd0);
        chk("reset err_overrun", 16'(err_overrun), 16'd0);
        chk("reset merge_ign", 16'(merge_ign), 16'd0);
        chk("reset rd_idx", 16'(rd_idx), 16'd0);
        chk("reset rd_root", 16'(rd_root), 16'd0);
`ifdef BLOB_ROOT_COUNT_EN
        chk("reset obj_count", 16'(obj_count), 16'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 4; k++) run_frame(vt[k], 0, 0, $sformatf("vec%0d", k));

        // Backpressure in the middle of the drain
        run_frame(vt[2], 3, 5, "stall");

        // Rejected merges, merge during FLATTEN, frame_start during DRAIN
        start_frame("ign");
        do_merge(4'd0, 4'd3, 1'b1, "ign");
        do_merge(4'd2, 4'd2, 1'b1, "ign");
        do_merge(4'd12, 4'd1, 1'b1, "ign");
        end_frame(4'd3);
        merge_valid = 1'b1; merge_a = 4'd2; merge_b = 4'd1;
        @(negedge clk);
        merge_valid = 1'b0;
        chk("ign merge in FLATTEN", 16'(merge_ign), 16'd1);
        run_drain("ign", 3, ident(), 2, 0, 0, 2);
`ifdef BLOB_ROOT_COUNT_EN
        chk("ign obj_count", 16'(obj_count), 16'd3);
`endif

        // Merge and frame_end in the same cycle
        start_frame("same");
        merge_valid = 1'b1; merge_a = 4'd2; merge_b = 4'd1;
        frame_end = 1'b1; max_label = 4'd2;
        @(negedge clk);
        merge_valid = 1'b0; frame_end = 1'b0;
        chk("same merge_ign", 16'(merge_ign), 16'd0);
        r = ident(); r[2] = 4'd1;
        run_drain("same", 2, r, 2, 0, 0, 0);

        // Empty frame
        start_frame("empty");
        end_frame(4'd0);
        chk("empty done", 16'(done), 16'd1);
        chk("empty rd_valid", 16'(rd_valid), 16'd0);
        chk("empty busy", 16'(busy), 16'd0);
        @(negedge clk);
        chk("empty done one cycle", 16'(done), 16'd0);
        chk("empty rd_valid later", 16'(rd_valid), 16'd0);
`ifdef BLOB_ROOT_COUNT_EN
        chk("empty obj_count", 16'(obj_count), 16'd0);
`endif

        // max_label beyond the table is clipped to 9
        start_frame("clip");
        do_merge(4'd9, 4'd1, 1'b0, "clip");
        end_frame(4'd15);
        r = ident(); r[9] = 4'd1;
        run_drain("clip", 9, r, 9, 0, 0, 0);
`ifdef BLOB_ROOT_COUNT_EN
        chk("clip obj_count", 16'(obj_count), 16'd8);
`endif

        // Reset in the middle of a drain
        start_frame("rst");
        do_merge(4'd5, 4'd2, 1'b0, "rst");
        end_frame(4'd5);
        w = 0;
        while (!rd_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("rst reached drain", 16'(rd_valid), 16'd1);
        rd_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst rd_valid", 16'(rd_valid), 16'd0);
        chk("rst busy", 16'(busy), 16'd0);
        chk("rst done", 16'(done), 16'd0);
        chk("rst rd_idx", 16'(rd_idx), 16'd0);
        chk("rst rd_root", 16'(rd_root), 16'd0);
        chk("rst err_overrun", 16'(err_overrun), 16'd0);
        chk("rst merge_ign", 16'(merge_ign), 16'd0);
`ifdef BLOB_ROOT_COUNT_EN
        chk("rst obj_count", 16'(obj_count), 16'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(vt[0], 0, 0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
